// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//
// 8N1 UART receiver, LSB first. Companion to uart_tx; both ends share the
// same CLKS_PER_BIT so the baud rates match.
//
// The serial line is double-flopped into r_Rx, which is the only line sample
// the state machine ever looks at. A falling edge on an idle line is confirmed
// as a start bit at its mid-point. Each data bit and the stop bit are then
// sampled one full bit period apart, which lands every sample on a bit centre.
//
// Parameters:
//   CLKS_PER_BIT   i_Clock cycles per bit period (4..16383, 14-bit counter)
//
// Ports:
//   i_Clock         system clock, rising edge
//   i_Reset         asynchronous, active-high reset
//   i_Rx_Serial     asynchronous serial input, idle high
//   o_Rx_DV         one-cycle strobe: o_Rx_Byte holds a newly received byte
//   o_Rx_Byte       last correctly framed byte, held until the next one
//   o_Rx_Active     high while a frame is being received
//   o_Rx_Frame_Err  one-cycle strobe: stop bit was sampled low
//
// State table:
//   IDLE    | line idle, waiting for a low sample
//   START   | counting to the middle of the start bit to confirm it
//   DATA    | sampling the 8 data bits at their centres
//   STOP    | sampling the stop bit, emitting the byte or a framing error
//   CLEANUP | waiting for the line to return high before re-arming
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  // The start check happens at H = CLKS_PER_BIT/2 - 1 rather than
  // CLKS_PER_BIT/2: the IDLE->START hop costs one cycle, so this puts the
  // start sample (and every later one) half a bit after its leading edge.
  localparam logic [13:0] HALF_COUNT = 14'(CLKS_PER_BIT / 2 - 1);
  localparam logic [13:0] LAST_COUNT = 14'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  state_t      r_State;
  state_t      w_State_Next;

  logic        r_Rx_Meta;
  logic        r_Rx;

  logic [13:0] r_Clock_Count;
  logic [13:0] w_Clock_Count_Next;
  logic [2:0]  r_Bit_Index;
  logic [2:0]  w_Bit_Index_Next;
  logic [7:0]  r_Rx_Shift;
  logic [7:0]  w_Rx_Shift_Next;

  logic [7:0]  w_Rx_Byte_Next;
  logic        w_Rx_DV_Next;
  logic        w_Rx_Active_Next;
  logic        w_Rx_Frame_Err_Next;

  // Two-flop synchroniser, reset to the idle (high) line level so that reset
  // release on an idle line never looks like a start bit.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Rx_Meta <= 1'b1;
      r_Rx      <= 1'b1;
    end else begin
      r_Rx_Meta <= i_Rx_Serial;
      r_Rx      <= r_Rx_Meta;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State        <= IDLE;
      r_Clock_Count  <= '0;
      r_Bit_Index    <= '0;
      r_Rx_Shift     <= '0;
      o_Rx_Byte      <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Active    <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      r_State        <= w_State_Next;
      r_Clock_Count  <= w_Clock_Count_Next;
      r_Bit_Index    <= w_Bit_Index_Next;
      r_Rx_Shift     <= w_Rx_Shift_Next;
      o_Rx_Byte      <= w_Rx_Byte_Next;
      o_Rx_DV        <= w_Rx_DV_Next;
      o_Rx_Active    <= w_Rx_Active_Next;
      o_Rx_Frame_Err <= w_Rx_Frame_Err_Next;
    end
  end

  always_comb begin
    w_State_Next        = r_State;
    w_Clock_Count_Next  = r_Clock_Count;
    w_Bit_Index_Next    = r_Bit_Index;
    w_Rx_Shift_Next     = r_Rx_Shift;
    w_Rx_Byte_Next      = o_Rx_Byte;
    w_Rx_DV_Next        = 1'b0;
    w_Rx_Active_Next    = o_Rx_Active;
    w_Rx_Frame_Err_Next = 1'b0;

    case (r_State)
      IDLE: begin
        w_Clock_Count_Next = '0;
        w_Bit_Index_Next   = '0;
        w_Rx_Active_Next   = 1'b0;
        if (!r_Rx) begin
          w_State_Next     = START;
          w_Rx_Active_Next = 1'b1;
        end
      end

      START: begin
        if (r_Clock_Count == HALF_COUNT) begin
          w_Clock_Count_Next = '0;
          if (!r_Rx) begin
            w_State_Next = DATA;
          end else begin
            // Line came back high before mid-bit: a glitch, not a frame.
            w_State_Next     = IDLE;
            w_Rx_Active_Next = 1'b0;
          end
        end else begin
          w_Clock_Count_Next = r_Clock_Count + 14'd1;
        end
      end

      DATA: begin
        if (r_Clock_Count == LAST_COUNT) begin
          w_Clock_Count_Next           = '0;
          w_Rx_Shift_Next[r_Bit_Index] = r_Rx;
          if (r_Bit_Index < 3'd7) begin
            w_Bit_Index_Next = r_Bit_Index + 3'd1;
          end else begin
            w_Bit_Index_Next = '0;
            w_State_Next     = STOP;
          end
        end else begin
          w_Clock_Count_Next = r_Clock_Count + 14'd1;
        end
      end

      STOP: begin
        if (r_Clock_Count == LAST_COUNT) begin
          w_Clock_Count_Next = '0;
          w_State_Next       = CLEANUP;
          if (r_Rx) begin
            w_Rx_Byte_Next = r_Rx_Shift;
            w_Rx_DV_Next   = 1'b1;
          end else begin
            w_Rx_Frame_Err_Next = 1'b1;
          end
        end else begin
          w_Clock_Count_Next = r_Clock_Count + 14'd1;
        end
      end

      CLEANUP: begin
        // A break or stuck-low line must not be re-read as a new start bit,
        // so re-arm only once the line has been seen high again.
        if (r_Rx) begin
          w_State_Next     = IDLE;
          w_Rx_Active_Next = 1'b0;
        end
      end

      default: begin
        w_State_Next       = IDLE;
        w_Clock_Count_Next = '0;
        w_Bit_Index_Next   = '0;
        w_Rx_Active_Next   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//
// Two receivers (CLKS_PER_BIT = 4 and 16) watch separately driven lines.
// Every sampled line value is recorded per clock edge; a frame-level model
// works out from those samples where each frame starts, which sample lands in
// each bit centre, and therefore when each strobe, byte and active window must
// appear. A single compare process checks all outputs against that model on
// every cycle, and each directed scenario adds literal expectations.
// ----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BIG     = 1 << 30;
  localparam int MAXC    = 8192;
  localparam int M_HIGH  = 0;
  localparam int M_LOW   = 1;
  localparam int M_FRAME = 2;

  logic       clk;
  logic       rst;
  logic [1:0] line;
  logic [1:0] dv;
  logic [1:0] act;
  logic [1:0] fe;
  logic [7:0] byt0;
  logic [7:0] byt1;

  int checks   = 0;
  int failures = 0;

  uart_rx #(.CLKS_PER_BIT(4)) dut0 (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Rx_Serial   (line[0]),
    .o_Rx_DV       (dv[0]),
    .o_Rx_Byte     (byt0),
    .o_Rx_Active   (act[0]),
    .o_Rx_Frame_Err(fe[0])
  );

  uart_rx #(.CLKS_PER_BIT(16)) dut1 (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Rx_Serial   (line[1]),
    .o_Rx_DV       (dv[1]),
    .o_Rx_Byte     (byt1),
    .o_Rx_Active   (act[1]),
    .o_Rx_Frame_Err(fe[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int   cyc;
  logic lh [2][MAXC];
  int   cpbv [2];
  int   mode [2];
  int   ptr [2];
  int   e0 [2];
  int   pend_s [2];
  logic pend_dv [2];
  logic [7:0] pend_byte [2];
  logic [7:0] exp_byte [2];
  int   rise [2];
  int   fall [2];
  int   prise [2];
  int   pfall [2];

  // ---------------- observation logs ----------------
  int         dvc0 [$];
  logic [7:0] dvb0 [$];
  logic [7:0] dvb1 [$];
  int         fe_n [2];
  int         act_run [2];
  int         act_last [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic get_l(input int i, input int idx);
    if (idx < 1 || idx >= MAXC) return 1'b1;
    return lh[i][idx];
  endfunction

  task automatic model_reset(input int i);
    mode[i]     = M_LOW;
    ptr[i]      = 1;
    e0[i]       = 0;
    pend_s[i]   = -1;
    pend_dv[i]  = 1'b0;
    pend_byte[i] = 8'h00;
    exp_byte[i] = 8'h00;
    rise[i]     = BIG;
    fall[i]     = BIG;
    prise[i]    = BIG;
    pfall[i]    = BIG;
    act_run[i]  = 0;
  endtask

  // Frame-level interpretation of the recorded line samples. The line sample
  // taken at edge n first influences the receiver two edges later (the
  // synchroniser), so a frame whose first low sample is at edge E0 starts
  // being active after edge E0+2, checks its start at sample E0+half, reads
  // bit k at sample E0+half+cpb*(k+1) and emits its result at stop-sample+2.
  task automatic model_step(input int i);
    int  t;
    int  half;
    int  c;
    logic [7:0] b;
    bit  progress;
    t    = cyc;
    half = cpbv[i] / 2;
    c    = cpbv[i];
    progress = 1'b1;
    while (progress) begin
      progress = 1'b0;
      case (mode[i])
        M_HIGH: if (ptr[i] <= t) begin
          if (get_l(i, ptr[i])) begin
            fall[i] = ptr[i] + 2;
            mode[i] = M_LOW;
          end
          ptr[i]++;
          progress = 1'b1;
        end
        M_LOW: if (ptr[i] <= t) begin
          if (!get_l(i, ptr[i])) begin
            prise[i] = rise[i];
            pfall[i] = fall[i];
            e0[i]    = ptr[i];
            rise[i]  = ptr[i] + 2;
            fall[i]  = BIG;
            mode[i]  = M_FRAME;
          end
          ptr[i]++;
          progress = 1'b1;
        end
        default: begin
          if (t >= e0[i] + half) begin
            if (get_l(i, e0[i] + half)) begin
              fall[i] = e0[i] + half + 2;
              mode[i] = M_LOW;
              ptr[i]  = e0[i] + half + 1;
              progress = 1'b1;
            end else if (t >= e0[i] + half + 9 * c) begin
              for (int k = 0; k < 8; k++) b[k] = get_l(i, e0[i] + half + c * (k + 1));
              pend_byte[i] = b;
              pend_dv[i]   = get_l(i, e0[i] + half + 9 * c);
              pend_s[i]    = e0[i] + half + 9 * c + 2;
              mode[i]      = M_HIGH;
              ptr[i]       = pend_s[i] - 1;
              progress = 1'b1;
            end
          end
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0;
    end else begin
      cyc = cyc + 1;
      if (cyc < MAXC) begin
        lh[0][cyc] = line[0];
        lh[1][cyc] = line[1];
      end
    end
  end

  // Single compare process: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) model_reset(i);
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic e_dv, e_fe, e_act;
        logic [7:0] g_byte;
        model_step(i);
        e_dv  = (pend_s[i] == cyc) && pend_dv[i];
        e_fe  = (pend_s[i] == cyc) && !pend_dv[i];
        if (e_dv) exp_byte[i] = pend_byte[i];
        e_act = (cyc >= rise[i] && cyc < fall[i]) || (cyc >= prise[i] && cyc < pfall[i]);
        g_byte = (i == 0) ? byt0 : byt1;
        chk($sformatf("dv%0d@%0d", i, cyc), 32'(dv[i]), 32'(e_dv));
        chk($sformatf("frame_err%0d@%0d", i, cyc), 32'(fe[i]), 32'(e_fe));
        chk($sformatf("byte%0d@%0d", i, cyc), 32'(g_byte), 32'(exp_byte[i]));
        chk($sformatf("active%0d@%0d", i, cyc), 32'(act[i]), 32'(e_act));
        if (dv[i]) begin
          if (i == 0) begin
            dvc0.push_back(cyc);
            dvb0.push_back(byt0);
          end else begin
            dvb1.push_back(byt1);
          end
        end
        if (fe[i]) fe_n[i]++;
        if (act[i]) act_run[i]++;
        else if (act_run[i] > 0) begin
          act_last[i] = act_run[i];
          act_run[i]  = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_logs();
    dvc0.delete();
    dvb0.delete();
    dvb1.delete();
    fe_n[0] = 0;
    fe_n[1] = 0;
    act_last[0] = 0;
    act_last[1] = 0;
  endtask

  // Call at a falling edge; each bit lasts exactly cpb clocks.
  task automatic send_frame(input int i, input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) begin
      if (k == 0) line[i] = 1'b0;
      else if (k == 9) line[i] = stop;
      else line[i] = b[k-1];
      repeat (cpbv[i]) @(negedge clk);
    end
  endtask

  // Frame on line 1 with the bit period scaled by pct/100. Transition times
  // are kept off the rising edges so line sampling is unambiguous.
  task automatic send_skew(input logic [7:0] b, input int pct);
    int prev;
    int off;
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) line[1] = 1'b0;
      else if (k == 9) line[1] = 1'b1;
      else line[1] = b[k-1];
      off = ((k + 1) * 160 * pct + 50) / 100;
      if (off % 10 == 5) off = off + 1;
      #(off - prev);
      prev = off;
    end
    @(negedge clk);
  endtask

  logic [7:0] b2b [4];
  int         e0_ref;

  initial begin
    cpbv[0] = 4;
    cpbv[1] = 16;
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h01;
    b2b[3] = 8'h80;
    line = 2'b11;
    rst  = 1'b1;
    cyc  = 0;
    for (int i = 0; i < 2; i++) model_reset(i);
    clear_logs();
    #1;
    chk("reset_dv", 32'(dv), 32'd0);
    chk("reset_active", 32'(act), 32'd0);
    chk("reset_frame_err", 32'(fe), 32'd0);
    chk("reset_byte0", 32'(byt0), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);

    // 0xA5: strobe latency and active window
    clear_logs();
    e0_ref = cyc + 1;
    send_frame(0, 8'hA5, 1'b1);
    repeat (12) @(negedge clk);
    chk("a5_count", 32'(dvc0.size()), 32'd1);
    if (dvc0.size() == 1) begin
      chk("a5_latency", 32'(dvc0[0] - e0_ref), 32'd40);
      chk("a5_byte", 32'(dvb0[0]), 32'hA5);
    end
    chk("a5_no_frame_err", 32'(fe_n[0]), 32'd0);
    chk("a5_active_len", 32'(act_last[0]), 32'd39);

    // back-to-back, no idle gap
    clear_logs();
    e0_ref = cyc + 1;
    for (int k = 0; k < 4; k++) send_frame(0, b2b[k], 1'b1);
    repeat (12) @(negedge clk);
    chk("b2b_count", 32'(dvc0.size()), 32'd4);
    if (dvc0.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("b2b_cycle%0d", k), 32'(dvc0[k] - e0_ref), 32'(40 + 40 * k));
        chk($sformatf("b2b_byte%0d", k), 32'(dvb0[k]), 32'(b2b[k]));
      end
    end

    // one-clock low glitch on the idle line
    clear_logs();
    line[0] = 1'b0;
    @(negedge clk);
    line[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_no_dv", 32'(dvc0.size()), 32'd0);
    chk("glitch_no_frame_err", 32'(fe_n[0]), 32'd0);
    chk("glitch_active_len", 32'(act_last[0]), 32'd2);

    // framing error, line held low 20 bit times, then a good frame
    clear_logs();
    send_frame(0, 8'h3C, 1'b0);
    repeat (80) @(negedge clk);
    chk("ferr_count", 32'(fe_n[0]), 32'd1);
    chk("ferr_no_dv", 32'(dvc0.size()), 32'd0);
    chk("ferr_byte_held", 32'(byt0), 32'h80);
    chk("ferr_active_held", 32'(act[0]), 32'd1);
    line[0] = 1'b1;
    repeat (8) @(negedge clk);
    send_frame(0, 8'h5A, 1'b1);
    repeat (12) @(negedge clk);
    chk("after_ferr_count", 32'(dvb0.size()), 32'd1);
    if (dvb0.size() == 1) chk("after_ferr_byte", 32'(dvb0[0]), 32'h5A);
    chk("after_ferr_frame_err", 32'(fe_n[0]), 32'd1);

    // reset during bit 4 of a frame
    line[0] = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      line[0] = k[0];
      repeat (4) @(negedge clk);
    end
    line[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("midframe_active", 32'(act[0]), 32'd1);
    #2;
    rst  = 1'b1;
    line = 2'b11;
    #1;
    chk("async_reset_dv", 32'(dv[0]), 32'd0);
    chk("async_reset_active", 32'(act[0]), 32'd0);
    chk("async_reset_frame_err", 32'(fe[0]), 32'd0);
    chk("async_reset_byte", 32'(byt0), 32'h00);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    clear_logs();
    send_frame(0, 8'h96, 1'b1);
    repeat (12) @(negedge clk);
    chk("post_reset_count", 32'(dvb0.size()), 32'd1);
    if (dvb0.size() == 1) chk("post_reset_byte", 32'(dvb0[0]), 32'h96);

    // randomized traffic, checked cycle by cycle against the model
    for (int n = 0; n < 30; n++) begin
      logic [7:0] rb;
      logic       rs;
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 4) == 0) begin
        line[0] = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        line[0] = 1'b1;
        repeat (8) @(negedge clk);
      end
      send_frame(0, rb, rs);
      if (!rs) repeat ($urandom_range(0, 12)) @(negedge clk);
      line[0] = 1'b1;
      repeat ($urandom_range(0, 9)) @(negedge clk);
    end
    repeat (60) @(negedge clk);

    // CLKS_PER_BIT=16 with +4% and -4% baud skew
    clear_logs();
    send_skew(8'hC3, 104);
    repeat (48) @(negedge clk);
    chk("skew_slow_count", 32'(dvb1.size()), 32'd1);
    if (dvb1.size() == 1) chk("skew_slow_byte", 32'(dvb1[0]), 32'hC3);
    chk("skew_slow_frame_err", 32'(fe_n[1]), 32'd0);
    clear_logs();
    send_skew(8'hC3, 96);
    repeat (48) @(negedge clk);
    chk("skew_fast_count", 32'(dvb1.size()), 32'd1);
    if (dvb1.size() == 1) chk("skew_fast_byte", 32'(dvb1[0]), 32'hC3);
    chk("skew_fast_frame_err", 32'(fe_n[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
